// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg: shared types and March C- element tables for the SRAM BIST controller.
package sram_bist_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
    } state_t;
    localparam logic [31:0] BG0 = 32'h0000_0000;
    localparam logic [31:0] BG1 = 32'hFFFF_FFFF;
    localparam int NUM_WORDS = 16384;
    localparam int RUN_CYCLES = 163840;
    // Element tables, bit n describes element Mn.
    localparam logic [7:0] EL_DOWN = 8'b0001_1000;
    localparam logic [7:0] EL_RD   = 8'b0011_1110;
    localparam logic [7:0] EL_WR   = 8'b0001_1111;
    localparam logic [7:0] EL_RVAL = 8'b0001_0100;
    localparam logic [7:0] EL_WVAL = 8'b0000_1010;
    function automatic int run_cycles(input int addr_w);
        return 10 * (2 ** (addr_w + 1));
    endfunction
endpackage

// File: rtl/sram_bist_addr_gen.sv
// sram_bist_addr_gen: {bank, word} up/down address counter with load and terminal count.
module sram_bist_addr_gen #(
    parameter int AW = 14
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          i_load,
    input  logic          i_down,
    input  logic          i_step,
    output logic [AW-1:0] o_addr,
    output logic          o_tc
);
    logic [AW-1:0] r_addr;
    logic          r_down;
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_addr <= '0;
            r_down <= 1'b0;
        end else if (i_load) begin
            r_addr <= i_down ? '1 : '0;
            r_down <= i_down;
        end else if (i_step) begin
            r_addr <= r_down ? r_addr - AW'(1) : r_addr + AW'(1);
        end
    end
    assign o_addr = r_addr;
    assign o_tc   = r_down ? (r_addr == '0) : (r_addr == '1);
endmodule

// File: rtl/sram_bist_ctrl.sv
// sram_bist_ctrl: March C- BIST for the two-bank SRAM array; functional pass-through while idle.
module sram_bist_ctrl #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 0
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              bist_start,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [ADDR_W:0]   fail_addr,
    output logic [7:0]        err_cnt,
    input  logic              func_w_en,
    input  logic [ADDR_W-1:0] func_addr,
    input  logic [DATA_W-1:0] func_wdata,
    input  logic [3:0]        func_bank0_csn,
    input  logic [3:0]        func_bank1_csn,
    output logic              sram_w_en,
    output logic [ADDR_W-1:0] sram_addr_out,
    output logic [DATA_W-1:0] sram_wdata,
    output logic [3:0]        bank0_csn,
    output logic [3:0]        bank1_csn,
    input  logic [DATA_W-1:0] bank0_rdata,
    input  logic [DATA_W-1:0] bank1_rdata
);
    import sram_bist_pkg::*;
    localparam int AW = ADDR_W + 1;

    state_t            r_state, w_nxt;
    logic              r_phase;
    logic [AW-1:0]     w_addr;
    logic              w_tc, w_in_m, w_two, w_rd, w_wr, w_step, w_last, w_start;
    logic [2:0]        w_el, w_ld_el;
    logic [DATA_W-1:0] w_exp, w_ce, w_rdata;
    logic [AW-1:0]     w_ca;
    logic              w_cv, w_miss;
    logic              r_fail;
    logic [AW-1:0]     r_faddr;
    logic [7:0]        r_cnt;

    // Two-op elements alternate read (phase 0) and write (phase 1) on one address.
    assign w_el    = 3'(r_state - S_M0);
    assign w_in_m  = (r_state >= S_M0) && (r_state <= S_M5);
    assign w_two   = EL_RD[w_el] & EL_WR[w_el];
    assign w_rd    = w_in_m & EL_RD[w_el] & ~(w_two & r_phase);
    assign w_wr    = w_in_m & EL_WR[w_el] & (~w_two | r_phase);
    assign w_step  = w_in_m & (~w_two | r_phase);
    assign w_last  = w_step & w_tc;
    assign w_start = (r_state == S_IDLE) & bist_start;
    assign w_ld_el = w_start ? 3'd0 : w_el + 3'd1;
    assign w_exp   = EL_RVAL[w_el] ? DATA_W'(BG1) : DATA_W'(BG0);

    sram_bist_addr_gen #(.AW(AW)) u_addr_gen (
        .hclk    (hclk),
        .hresetn (hresetn),
        .i_load  (w_start | w_last),
        .i_down  (EL_DOWN[w_ld_el]),
        .i_step  (w_step),
        .o_addr  (w_addr),
        .o_tc    (w_tc)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= S_IDLE;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_phase <= w_in_m & w_two & ~r_phase;
        end
    end

    always_comb begin
        w_nxt = w_start ? S_M0 :
                (r_state == S_DONE) ? S_IDLE :
                (r_state == S_DRAIN) ? S_DONE :
                !w_last ? r_state :
                (r_state == S_M5) ? ((RD_LAT != 0) ? S_DRAIN : S_DONE) :
                state_t'(r_state + 4'd1);
        bist_busy     = w_in_m | (r_state == S_DRAIN);
        bist_done     = (r_state == S_DONE);
        sram_w_en     = bist_busy ? ~w_wr : func_w_en;
        sram_addr_out = bist_busy ? w_addr[ADDR_W-1:0] : func_addr;
        sram_wdata    = bist_busy ? ((w_wr & EL_WVAL[w_el]) ? DATA_W'(BG1) : DATA_W'(BG0)) : func_wdata;
        bank0_csn     = bist_busy ? ((w_in_m & ~w_addr[ADDR_W]) ? 4'b0000 : 4'b1111) : func_bank0_csn;
        bank1_csn     = bist_busy ? ((w_in_m & w_addr[ADDR_W]) ? 4'b0000 : 4'b1111) : func_bank1_csn;
    end

    // Expected data and address follow the SRAM read latency.
    if (RD_LAT == 0) begin : g_lat0
        assign w_cv = w_rd;
        assign w_ce = w_exp;
        assign w_ca = w_addr;
    end else begin : g_lat1
        logic              r_cv;
        logic [DATA_W-1:0] r_ce;
        logic [AW-1:0]     r_ca;
        always_ff @(posedge hclk or negedge hresetn) begin
            if (!hresetn) begin
                r_cv <= 1'b0;
                r_ce <= '0;
                r_ca <= '0;
            end else begin
                r_cv <= w_rd;
                r_ce <= w_exp;
                r_ca <= w_addr;
            end
        end
        assign w_cv = r_cv;
        assign w_ce = r_ce;
        assign w_ca = r_ca;
    end

    assign w_rdata = w_ca[ADDR_W] ? bank1_rdata : bank0_rdata;
    assign w_miss  = w_cv & (w_rdata != w_ce);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_fail  <= 1'b0;
            r_faddr <= '0;
            r_cnt   <= '0;
        end else if (w_start) begin
            r_fail  <= 1'b0;
            r_faddr <= '0;
            r_cnt   <= '0;
        end else if (w_miss) begin
            r_fail <= 1'b1;
            if (!r_fail) r_faddr <= w_ca;
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
        end
    end

    assign bist_fail = r_fail;
    assign fail_addr = r_faddr;
    assign err_cnt   = r_cnt;
endmodule

// File: tb/tb_sram_bist_ctrl.sv
// tb_sram_bist_ctrl: checks pass-through and March C- runs for RD_LAT 0 and 1 side by side.
module tb_sram_bist_ctrl;
    localparam int AW  = 7;
    localparam int DW  = 32;
    localparam int NW  = 2 ** (AW + 1);
    localparam int RUN = 10 * NW;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    c0;
        logic [3:0]    c1;
    } pt_t;

    typedef struct {
        bit          fail;
        logic [AW:0] fa;
        int          cnt;
        int          lat;
    } exp_t;

    logic          hclk = 1'b0;
    logic          hresetn = 1'b0;
    logic          bist_start = 1'b0;
    logic          func_w_en = 1'b1;
    logic [AW-1:0] func_addr = '0;
    logic [DW-1:0] func_wdata = '0;
    logic [3:0]    func_bank0_csn = 4'hF;
    logic [3:0]    func_bank1_csn = 4'hF;

    logic          busy [2];
    logic          done [2];
    logic          fail [2];
    logic [AW:0]   faddr [2];
    logic [7:0]    ecnt [2];
    logic          s_we [2];
    logic [AW-1:0] s_addr [2];
    logic [DW-1:0] s_wd [2];
    logic [3:0]    cs0 [2];
    logic [3:0]    cs1 [2];

    int   flt_mode = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sbq0[$];
    exp_t sbq1[$];
    pt_t  vt [4];

    always #5 hclk = ~hclk;

    function automatic logic [DW-1:0] flt(input logic [AW:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        if (flt_mode == 1 && a == {1'b1, AW'(5)}) r[0] = 1'b1;
        if (flt_mode == 2 && !a[AW]) r[31] = 1'b0;
        return r;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] w, input logic [3:0] cs);
        logic [DW-1:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (!cs[k]) r[8*k +: 8] = w[8*k +: 8];
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] mem [NW];
        logic [DW-1:0] rd0, rd1;
        sram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(g)) u_dut (
            .hclk           (hclk),
            .hresetn        (hresetn),
            .bist_start     (bist_start),
            .bist_busy      (busy[g]),
            .bist_done      (done[g]),
            .bist_fail      (fail[g]),
            .fail_addr      (faddr[g]),
            .err_cnt        (ecnt[g]),
            .func_w_en      (func_w_en),
            .func_addr      (func_addr),
            .func_wdata     (func_wdata),
            .func_bank0_csn (func_bank0_csn),
            .func_bank1_csn (func_bank1_csn),
            .sram_w_en      (s_we[g]),
            .sram_addr_out  (s_addr[g]),
            .sram_wdata     (s_wd[g]),
            .bank0_csn      (cs0[g]),
            .bank1_csn      (cs1[g]),
            .bank0_rdata    (rd0),
            .bank1_rdata    (rd1)
        );
        always @(posedge hclk) begin
            if (!s_we[g] && cs0[g] != 4'hF) mem[{1'b0, s_addr[g]}] <= merge(mem[{1'b0, s_addr[g]}], s_wd[g], cs0[g]);
            if (!s_we[g] && cs1[g] != 4'hF) mem[{1'b1, s_addr[g]}] <= merge(mem[{1'b1, s_addr[g]}], s_wd[g], cs1[g]);
        end
        if (g == 0) begin : g_comb
            assign rd0 = flt({1'b0, s_addr[g]}, mem[{1'b0, s_addr[g]}]);
            assign rd1 = flt({1'b1, s_addr[g]}, mem[{1'b1, s_addr[g]}]);
        end else begin : g_reg
            always @(posedge hclk) begin
                rd0 <= flt({1'b0, s_addr[g]}, mem[{1'b0, s_addr[g]}]);
                rd1 <= flt({1'b1, s_addr[g]}, mem[{1'b1, s_addr[g]}]);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic func_idle();
        func_w_en = 1'b1;
        func_addr = '0;
        func_wdata = '0;
        func_bank0_csn = 4'hF;
        func_bank1_csn = 4'hF;
    endtask

    // mode: 0 plain, 1 functional write during M2, 2 start held high, 3 reset during M3
    task automatic run_bist(input string tag, input int mode, input bit ef, input logic [AW:0] efa, input int ecn);
        int   got [2];
        int   nd [2];
        exp_t e;
        got = '{-1, -1};
        nd = '{0, 0};
        if (mode != 3) begin
            sbq0.push_back('{ef, efa, ecn, RUN});
            sbq1.push_back('{ef, efa, ecn, RUN + 1});
        end
        bist_start = 1'b1;
        @(posedge hclk);
        #1;
        if (mode != 2) bist_start = 1'b0;
        for (int k = 0; k < RUN + 10; k++) begin
            @(negedge hclk);
            for (int d = 0; d < 2; d++) begin
                if (k == 0) begin
                    chk($sformatf("%s d%0d busy_at_start", tag, d), busy[d], 1);
                    chk($sformatf("%s d%0d cnt_cleared", tag, d), ecnt[d], 0);
                    chk($sformatf("%s d%0d fail_cleared", tag, d), fail[d], 0);
                end
                if (done[d]) begin
                    if (got[d] < 0) got[d] = k;
                    nd[d]++;
                end
            end
            if (k == RUN - 1) chk($sformatf("%s d0 busy_last", tag), busy[0], 1);
            if (k == RUN) chk($sformatf("%s d0 busy_in_done", tag), busy[0], 0);
            if (mode == 1 && k == 3 * NW + 10) begin
                func_w_en = 1'b0;
                func_addr = AW'(7'h33);
                func_wdata = 32'hDEADBEEF;
                func_bank0_csn = 4'h0;
                func_bank1_csn = 4'h0;
                #1;
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("%s d%0d m2_rd_wen", tag, d), s_we[d], 1);
                    chk($sformatf("%s d%0d m2_rd_addr", tag, d), s_addr[d], 5);
                    chk($sformatf("%s d%0d m2_rd_cs0", tag, d), cs0[d], 4'h0);
                    chk($sformatf("%s d%0d m2_rd_cs1", tag, d), cs1[d], 4'hF);
                end
            end
            if (mode == 1 && k == 3 * NW + 11) begin
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("%s d%0d m2_wr_wen", tag, d), s_we[d], 0);
                    chk($sformatf("%s d%0d m2_wr_addr", tag, d), s_addr[d], 5);
                    chk($sformatf("%s d%0d m2_wr_data", tag, d), s_wd[d], 0);
                end
                func_idle();
            end
            if (mode == 2 && k == RUN - 4) bist_start = 1'b0;
            if (mode == 3 && k == 5 * NW + 10) begin
                for (int d = 0; d < 2; d++) chk($sformatf("%s d%0d cnt_after_m2", tag, d), ecnt[d], 128);
                func_addr = AW'(7'h2A);
                hresetn = 1'b0;
                #1;
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("%s d%0d rst_busy", tag, d), busy[d], 0);
                    chk($sformatf("%s d%0d rst_cnt", tag, d), ecnt[d], 0);
                    chk($sformatf("%s d%0d rst_fail", tag, d), fail[d], 0);
                    chk($sformatf("%s d%0d rst_pass_addr", tag, d), s_addr[d], 7'h2A);
                    chk($sformatf("%s d%0d rst_pass_cs0", tag, d), cs0[d], 4'hF);
                end
                @(posedge hclk);
                #1;
                hresetn = 1'b1;
                func_idle();
                return;
            end
        end
        for (int d = 0; d < 2; d++) begin
            e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
            chk($sformatf("%s d%0d done_latency", tag, d), got[d], e.lat);
            chk($sformatf("%s d%0d done_pulses", tag, d), nd[d], 1);
            chk($sformatf("%s d%0d fail", tag, d), fail[d], e.fail);
            chk($sformatf("%s d%0d fail_addr", tag, d), faddr[d], e.fa);
            chk($sformatf("%s d%0d err_cnt", tag, d), ecnt[d], e.cnt);
            chk($sformatf("%s d%0d idle_busy", tag, d), busy[d], 0);
        end
    endtask

    initial begin
        vt[0] = '{1'b0, 7'h3C, 32'hDEADBEEF, 4'b1100, 4'b1111};
        vt[1] = '{1'b1, 7'h00, 32'h0000_0000, 4'b1111, 4'b0000};
        vt[2] = '{1'b0, 7'h7F, 32'h1234_5678, 4'b0101, 4'b1010};
        vt[3] = '{1'b1, 7'h55, 32'hA5A5_5A5A, 4'b0011, 4'b0011};
        repeat (3) @(posedge hclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset d%0d busy", d), busy[d], 0);
            chk($sformatf("reset d%0d done", d), done[d], 0);
            chk($sformatf("reset d%0d fail", d), fail[d], 0);
            chk($sformatf("reset d%0d fail_addr", d), faddr[d], 0);
            chk($sformatf("reset d%0d err_cnt", d), ecnt[d], 0);
        end
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        foreach (vt[i]) begin
            func_w_en = vt[i].we;
            func_addr = vt[i].a;
            func_wdata = vt[i].d;
            func_bank0_csn = vt[i].c0;
            func_bank1_csn = vt[i].c1;
            #1;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("pass%0d d%0d w_en", i, d), s_we[d], vt[i].we);
                chk($sformatf("pass%0d d%0d addr", i, d), s_addr[d], vt[i].a);
                chk($sformatf("pass%0d d%0d wdata", i, d), s_wd[d], vt[i].d);
                chk($sformatf("pass%0d d%0d cs0", i, d), cs0[d], vt[i].c0);
                chk($sformatf("pass%0d d%0d cs1", i, d), cs1[d], vt[i].c1);
            end
            @(posedge hclk);
            #1;
        end
        func_idle();
        run_bist("clean", 1, 1'b0, '0, 0);
        flt_mode = 1;
        run_bist("sa1_b1w5", 0, 1'b1, {1'b1, AW'(5)}, 3);
        flt_mode = 2;
        run_bist("sa0_b0d31", 2, 1'b1, '0, 255);
        run_bist("abort_m3", 3, 1'b0, '0, 0);
        flt_mode = 0;
        run_bist("rerun", 0, 1'b0, '0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
- March C- memory built-in self-test controller for the two-bank (2 x 8K x 32, byte-lane chip-selects) SRAM array behind the AHB SRAM slave interface.
- Sits between the slave interface's SRAM-side outputs and the SRAM macros.
- Idle: passes functional accesses through combinationally.
- Test run: takes exclusive ownership of the SRAM pins, sequences the full March C- algorithm, compares read data and reports pass/fail with the first failing address.

Parameters:
- ADDR_W, 13, word address width per bank.
- DATA_W, 32, bank word width (4 byte lanes).
- RD_LAT, 0, SRAM read latency in cycles. 0 = combinational read, 1 = registered read; only these two values are legal.

Ports:
- hclk  in  1  system clock.
- hresetn  in  1  async active-low reset.
- bist_start  in  1  level; sampled only in IDLE.
- bist_busy  out  1  high while BIST owns the SRAM.
- bist_done  out  1  one-cycle completion pulse.
- bist_fail  out  1  sticky; any miscompare in the last run.
- fail_addr  out  ADDR_W+1  {bank, word addr} of the first miscompare.
- err_cnt  out  8  miscompare count, saturating at 255.
- func_w_en  in  1  functional write enable (0 = write).
- func_addr  in  ADDR_W  functional word address.
- func_wdata  in  DATA_W  functional write data.
- func_bank0_csn  in  4  functional bank0 lane selects (active low).
- func_bank1_csn  in  4  functional bank1 lane selects (active low).
- sram_w_en  out  1  to SRAM (0 = write).
- sram_addr_out  out  ADDR_W  to SRAM.
- sram_wdata  out  DATA_W  to SRAM.
- bank0_csn  out  4  to SRAM bank0.
- bank1_csn  out  4  to SRAM bank1.
- bank0_rdata  in  DATA_W  bank0 read data {q3,q2,q1,q0}.
- bank1_rdata  in  DATA_W  bank1 read data {q7,q6,q5,q4}.

Behaviour:
- Reset values: bist_busy=0, bist_done=0, bist_fail=0, fail_addr=0, err_cnt=0, state=IDLE. SRAM outputs are in pass-through.
- Pass-through: when bist_busy=0, each SRAM output equals its func_* counterpart in the same cycle, with no register.
- Test-mode drive: when bist_busy=1, the SRAM outputs are driven only by BIST. Functional inputs are ignored and dropped; the system must not issue traffic during a test.
- Address counter: 14 bits, {bank, word}, covering 0..16383. Bit 13 = 0 selects bank0, so that bank's csn=4'b0000 and the other bank's csn=4'b1111.
- Transfer size: all BIST accesses are full-word.
- March elements: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0).
  - Data value 0 = 32'h0000_0000; data value 1 = 32'hFFFF_FFFF.
  - Elements with a read and a write spend 2 cycles per address: read then write, same address. Single-op elements spend 1 cycle per address.
- States: IDLE -> M0 -> M1 -> M2 -> M3 -> M4 -> M5 -> DRAIN -> DONE -> IDLE.
  - An element advances after its last address: 16383 for up elements, 0 for down elements.
  - The counter is loaded with 0 (up) or 16383 (down) on element entry.
- Start: start edge = the edge at which bist_start=1 is sampled in IDLE.
  - bist_busy rises after that edge.
  - bist_fail, fail_addr and err_cnt clear on that same edge.
  - bist_start is ignored in every other state.
- Run length: 163840 access cycles. DRAIN lasts RD_LAT cycles, during which SRAM outputs are w_en=1 and csn all 1.
- Done: DONE lasts 1 cycle. bist_done=1 and bist_busy=0 in that cycle.
  - bist_done is high in the cycle beginning 163840+RD_LAT edges after the start edge.
  - The state then returns to IDLE.
- Compare:
  - Expected data and address are delayed RD_LAT cycles.
  - Read data is taken from the bank given by the delayed bank bit.
  - A miscompare sets bist_fail and increments err_cnt (saturating).
  - On the first miscompare of a run, fail_addr latches the delayed address.
- Results: hold after DONE until the next start edge.
- Reset mid-run: asynchronous return to reset values and pass-through; any partial SRAM contents are undefined.

Decomposition:
- Package sram_bist_pkg:
  - state enum (IDLE, M0..M5, DRAIN, DONE);
  - BG0/BG1 data constants;
  - NUM_WORDS=16384;
  - RUN_CYCLES=163840;
  - per-element direction/op tables.
- Sub-module sram_bist_addr_gen: 14-bit up/down counter with load, step enable and terminal-count flag.

Test Plan:
- Fault-free model, RD_LAT=0, bist_start pulse -> bist_busy=1 for 163840 cycles; bist_done pulses exactly once 163840 edges after start; bist_fail=0, err_cnt=0.
- Bank1 word 0x0005 bit0 stuck-at-1, RD_LAT=1 -> first miscompare in M1; fail_addr=14'h2005, bist_fail=1, err_cnt=3 (M1, M3, M5 reads of 0); bist_done at start+163841.
- Idle pass-through: func_addr=13'h1ABC, func_w_en=0, func_wdata=32'hDEADBEEF, func_bank0_csn=4'b1100 -> same values on the SRAM outputs in the same cycle; bank1_csn follows func_bank1_csn=4'b1111.
- Functional write issued during M2 -> SRAM outputs show only BIST values; the functional data never reaches the SRAM model.
- hresetn low for 1 cycle during M3 -> immediately bist_busy=0, err_cnt=0, pass-through restored; a new start runs the full 163840 cycles.
- Bank0 data bit 31 stuck-at-0 on all words -> err_cnt saturates at 255; fail_addr=14'h0000; bist_start held high during the run has no effect until IDLE.
